fetch_exec_sequencer: RTL and testbench
=======================================

FETCH_EXEC_SEQUENCER -- requirements
Module: fetch_exec_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set memory/PC address width.
REQ-002 Parameter DATA_W, default 16, SHALL set instruction and memory data width.
REQ-003 Parameter MEM_LAT, default 0, range 0..7, SHALL set memory read wait cycles; 0 means read data is valid in the cycle the address is driven.
REQ-004 Parameter CNT_W, default 16, SHALL set retired-instruction counter width.
REQ-005 clock in 1: single clock; all state changes on its rising edge.
REQ-006 reset in 1: asynchronous, active-low reset.
REQ-007 pc_address in ADDR_W: current PC from datapath.
REQ-008 alu_address in ADDR_W: load/store address from datapath.
REQ-009 mem_address_select in 1: datapath requests a data access this instruction.
REQ-010 mem_write_request in 1: the data access is a store; ignored unless mem_address_select=1.
REQ-011 halt_request in 1: current instruction is HLT.
REQ-012 stall in 1: external hold; freezes the sequencer.
REQ-013 mem_read_data in DATA_W: shared memory read data.
REQ-014 instruction_register out DATA_W: latched instruction.
REQ-015 mem_address out ADDR_W: address to shared memory.
REQ-016 mem_write_enable out 1: store strobe to memory.
REQ-017 pc_write_enable out 1: one-cycle PC update permission.
REQ-018 load_valid out 1: mem_read_data holds load data this cycle.
REQ-019 halted out 1: sequencer in HALTED.
REQ-020 state_out out 3: encoded current state, for debug.
REQ-021 retired_count out CNT_W: instructions completed.

Function
REQ-022 States SHALL be FETCH=0, EXECUTE=1, LOAD_WAIT=2, HALTED=3; encodings above 3 SHALL be unreachable and SHALL recover to FETCH.
REQ-023 FETCH: mem_address=pc_address; wait counter runs MEM_LAT cycles; on final cycle instruction_register<=mem_read_data, go EXECUTE; FETCH lasts exactly 1+MEM_LAT cycles.
REQ-024 EXECUTE with halt_request=1: go HALTED; no pc_write_enable, no write, no count.
REQ-025 EXECUTE, no data access: pc_write_enable=1 for one cycle, go FETCH.
REQ-026 EXECUTE, store: mem_address=alu_address, mem_write_enable=1 and pc_write_enable=1 for that one cycle, go FETCH.
REQ-027 EXECUTE, load, MEM_LAT=0: mem_address=alu_address, load_valid=1, pc_write_enable=1 same cycle, go FETCH.
REQ-028 EXECUTE, load, MEM_LAT>0: mem_address=alu_address, go LOAD_WAIT; LOAD_WAIT holds alu_address for MEM_LAT cycles, asserting load_valid and pc_write_enable on its last cycle only, then FETCH.
REQ-029 mem_address SHALL equal pc_address in every state/cycle not named in REQ-026..028.
REQ-030 mem_write_enable SHALL never assert outside EXECUTE, nor when halt_request=1.
REQ-031 stall=1: state, wait counter, instruction_register and retired_count hold; mem_write_enable, pc_write_enable, load_valid forced 0; mem_address holds its current-state value.
REQ-032 retired_count SHALL increment by 1 on every cycle with pc_write_enable=1, wrapping modulo 2^CNT_W.
REQ-033 HALTED: halted=1, all strobes 0, mem_address=pc_address; exit only via reset.
REQ-034 Priority: reset > stall > halt_request > store/load decode.

Reset
REQ-035 reset=0 SHALL immediately force state=FETCH, wait counter=0, instruction_register=0, retired_count=0, all strobes 0, halted=0.
REQ-036 Reset asserted mid-FETCH, mid-LOAD_WAIT or during a store cycle SHALL abort it without any write strobe; first post-release fetch begins at pc_address.

Structure
REQ-037 State encodings and MEM_LAT bound SHALL live in a shared package used by cpu-level logic and benches.
REQ-038 Wait counter SHALL be one sub-module, wait_timer (load MEM_LAT, count down, done flag, hold on stall).

Verification
REQ-039 MEM_LAT=0, ALU instr 16'h1234 at PC 0x00 -> IR=16'h1234 after cycle 1, pc_write_enable in cycle 2, retired_count=1.
REQ-040 MEM_LAT=2, load from 0x40 -> FETCH 3 cycles, EXECUTE 1, LOAD_WAIT 2, load_valid/pc_write_enable only in cycle 6, mem_address=0x40 in cycles 4..6.
REQ-041 Store to 0x80 with stall=1 in the EXECUTE cycle for 3 cycles -> no mem_write_enable during stall, exactly one pulse at 0x80 after release.
REQ-042 HLT after 5 instructions -> halted=1, retired_count=5, no further strobes for 100 cycles.
REQ-043 reset=0 asynchronously in LOAD_WAIT cycle 1 -> outputs zero before next clock edge, state_out=0.
REQ-044 CNT_W=4, 17 instructions -> retired_count wraps to 1.

Source files
------------

// File: rtl/fetch_exec_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer and anything that
// observes it (cpu-level glue, benches).
//   - seq_state_e : debug-visible state encoding driven on state_out
//   - MEM_LAT_MAX : largest supported memory read latency
//   - WAIT_W      : width of the latency wait counter
package fetch_exec_sequencer_pkg;

    localparam int unsigned MEM_LAT_MAX = 7;
    localparam int unsigned WAIT_W      = $clog2(MEM_LAT_MAX + 1);

    // Encodings 4..7 are never produced and fall back to ST_FETCH.
    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_EXECUTE   = 3'd1,
        ST_LOAD_WAIT = 3'd2,
        ST_HALTED    = 3'd3
    } seq_state_e;

endpackage

// File: rtl/fetch_exec_sequencer_wait.sv
// wait_timer: paces the memory-latency phases of the sequencer.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (counter -> 0)
//   run_i   : a latency phase is in progress this cycle
//   hold_i  : freeze the counter (stall)
//   done_o  : this is the final cycle of the current latency window
// The counter records elapsed wait cycles since the window opened and
// reports done once it reaches LAT, so a window is LAT+1 cycles long and
// the idle value (0) doubles as the reset value.
module wait_timer
    import fetch_exec_sequencer_pkg::*;
#(
    parameter int unsigned LAT = 0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic hold_i,
    output logic done_o
);

    localparam logic [WAIT_W-1:0] LAT_V = WAIT_W'(LAT);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == LAT_V);

    always_comb begin
        cnt_d = cnt_q;
        if (!hold_i) begin
            cnt_d = (run_i && !done_o) ? cnt_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/fetch_exec_sequencer.sv
// fetch_exec_sequencer: multi-cycle FETCH / EXECUTE / LOAD_WAIT / HALTED
// control for a CPU sharing one memory port between instruction fetch and
// data access.
//   clock, reset (async, active-low)
//   pc_address, alu_address     : fetch and data addresses from the datapath
//   mem_address_select          : instruction performs a data access
//   mem_write_request           : that access is a store
//   halt_request                : instruction is HLT
//   stall                       : external hold, freezes the sequencer
//   mem_read_data               : shared memory read data
//   instruction_register        : latched instruction
//   mem_address                 : address to shared memory
//   mem_write_enable            : store strobe
//   pc_write_enable             : one-cycle PC update / retire strobe
//   load_valid                  : mem_read_data holds load data this cycle
//   halted, state_out           : status / debug
//   retired_count               : retired instructions, wraps
module fetch_exec_sequencer
    import fetch_exec_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_address,
    input  logic [ADDR_W-1:0] alu_address,
    input  logic              mem_address_select,
    input  logic              mem_write_request,
    input  logic              halt_request,
    input  logic              stall,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] instruction_register,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write_enable,
    output logic              pc_write_enable,
    output logic              load_valid,
    output logic              halted,
    output logic [2:0]        state_out,
    output logic [CNT_W-1:0]  retired_count
);

    localparam bit LAT_ZERO = (MEM_LAT == 0);

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wait_run, wait_done;
    logic              is_store, is_load;

    assign is_store = mem_address_select &  mem_write_request;
    assign is_load  = mem_address_select & ~mem_write_request;

    wait_timer #(.LAT(MEM_LAT)) u_wait (
        .clk_i  (clock),
        .rst_ni (reset),
        .run_i  (wait_run),
        .hold_i (stall),
        .done_o (wait_done)
    );

    always_comb begin
        state_d          = state_q;
        ir_d             = ir_q;
        wait_run         = 1'b0;
        mem_address      = pc_address;
        mem_write_enable = 1'b0;
        pc_write_enable  = 1'b0;
        load_valid       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                wait_run = 1'b1;
                if (wait_done) begin
                    ir_d    = mem_read_data;
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (halt_request) begin
                    state_d = ST_HALTED;
                end else begin
                    if (mem_address_select) mem_address = alu_address;
                    state_d         = ST_FETCH;
                    pc_write_enable = 1'b1;
                    if (is_store) begin
                        mem_write_enable = 1'b1;
                    end else if (is_load) begin
                        if (LAT_ZERO) begin
                            load_valid = 1'b1;
                        end else begin
                            // The EXECUTE cycle opens the latency window,
                            // leaving exactly MEM_LAT cycles in LOAD_WAIT.
                            pc_write_enable = 1'b0;
                            wait_run        = 1'b1;
                            state_d         = ST_LOAD_WAIT;
                        end
                    end
                end
            end
            ST_LOAD_WAIT: begin
                mem_address = alu_address;
                wait_run    = 1'b1;
                if (wait_done) begin
                    load_valid      = 1'b1;
                    pc_write_enable = 1'b1;
                    state_d         = ST_FETCH;
                end
            end
            ST_HALTED: begin
            end
            default: state_d = ST_FETCH;
        endcase

        // Stall freezes progress but keeps the current state's address.
        if (stall) begin
            state_d          = state_q;
            ir_d             = ir_q;
            mem_write_enable = 1'b0;
            pc_write_enable  = 1'b0;
            load_valid       = 1'b0;
        end

        cnt_d = pc_write_enable ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instruction_register = ir_q;
    assign halted               = (state_q == ST_HALTED);
    assign state_out            = state_q;
    assign retired_count        = cnt_q;

endmodule

// File: tb/tb_fetch_exec_sequencer.sv
module tb_fetch_exec_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  pc_address = '0, alu_address = '0;
    logic        msel = 1'b0, mwr = 1'b0, halt = 1'b0, stall = 1'b0;
    logic [15:0] rdata = '0;

    logic [15:0] ir0, ir2;
    logic [7:0]  a0, a2;
    logic        we0, we2, pw0, pw2, lv0, lv2, h0, h2;
    logic [2:0]  s0, s2;
    logic [3:0]  c0;
    logic [15:0] c2;

    always #5 clock = ~clock;

    fetch_exec_sequencer #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(0), .CNT_W(4)) u0 (
        .clock(clock), .reset(reset), .pc_address(pc_address), .alu_address(alu_address),
        .mem_address_select(msel), .mem_write_request(mwr), .halt_request(halt),
        .stall(stall), .mem_read_data(rdata), .instruction_register(ir0),
        .mem_address(a0), .mem_write_enable(we0), .pc_write_enable(pw0),
        .load_valid(lv0), .halted(h0), .state_out(s0), .retired_count(c0));

    fetch_exec_sequencer #(.ADDR_W(8), .DATA_W(16), .MEM_LAT(2), .CNT_W(16)) u2 (
        .clock(clock), .reset(reset), .pc_address(pc_address), .alu_address(alu_address),
        .mem_address_select(msel), .mem_write_request(mwr), .halt_request(halt),
        .stall(stall), .mem_read_data(rdata), .instruction_register(ir2),
        .mem_address(a2), .mem_write_enable(we2), .pc_write_enable(pw2),
        .load_valid(lv2), .halted(h2), .state_out(s2), .retired_count(c2));

    // DUT outputs gathered by instance index (0: MEM_LAT=0, 1: MEM_LAT=2)
    logic [15:0] d_ir[2], d_ret[2];
    logic [7:0]  d_a[2];
    logic [2:0]  d_s[2];
    logic        d_we[2], d_pw[2], d_lv[2], d_h[2];
    always_comb begin
        d_ir[0] = ir0; d_ir[1] = ir2;
        d_ret[0] = {12'b0, c0}; d_ret[1] = c2;
        d_a[0] = a0; d_a[1] = a2;
        d_s[0] = s0; d_s[1] = s2;
        d_we[0] = we0; d_we[1] = we2;
        d_pw[0] = pw0; d_pw[1] = pw2;
        d_lv[0] = lv0; d_lv[1] = lv2;
        d_h[0] = h0; d_h[1] = h2;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase per spec encoding plus cycles left in the phase.
    int          m_lat[2]  = '{0, 2};
    int          m_cntw[2] = '{4, 16};
    int          m_phase[2];
    int          m_left[2];
    logic [15:0] m_ir[2];
    int unsigned m_ret[2];

    task automatic m_reset(input int i);
        m_phase[i] = 0;
        m_left[i]  = 1 + m_lat[i];
        m_ir[i]    = '0;
        m_ret[i]   = 0;
    endtask

    task automatic m_expect(input int i, output logic [7:0] a, output logic we,
                            output logic pw, output logic lv, output logic hl);
        a = pc_address; we = 0; pw = 0; lv = 0;
        hl = (m_phase[i] == 3);
        if (m_phase[i] == 1 && !halt && msel) a = alu_address;
        if (m_phase[i] == 2) a = alu_address;
        if (!stall) begin
            if (m_phase[i] == 1 && !halt) begin
                if (msel && mwr) begin we = 1; pw = 1; end
                else if (msel) begin
                    if (m_lat[i] == 0) begin lv = 1; pw = 1; end
                end else pw = 1;
            end
            if (m_phase[i] == 2 && m_left[i] == 1) begin lv = 1; pw = 1; end
        end
    endtask

    task automatic m_advance(input int i);
        logic [7:0] a;
        logic we, pw, lv, hl;
        m_expect(i, a, we, pw, lv, hl);
        if (stall) return;
        if (pw) m_ret[i]++;
        case (m_phase[i])
            0: begin
                m_left[i]--;
                if (m_left[i] == 0) begin m_ir[i] = rdata; m_phase[i] = 1; end
            end
            1: begin
                if (halt) m_phase[i] = 3;
                else if (msel && !mwr && m_lat[i] > 0) begin m_phase[i] = 2; m_left[i] = m_lat[i]; end
                else begin m_phase[i] = 0; m_left[i] = 1 + m_lat[i]; end
            end
            2: begin
                m_left[i]--;
                if (m_left[i] == 0) begin m_phase[i] = 0; m_left[i] = 1 + m_lat[i]; end
            end
            default: ;
        endcase
    endtask

    // Called at a falling edge with inputs already driven; returns at the next one.
    task automatic cycle();
        logic [7:0] ea;
        logic ewe, epw, elv, ehl;
        logic [31:0] mask;
        if (!reset) begin m_reset(0); m_reset(1); end
        #1;
        for (int i = 0; i < 2; i++) begin
            m_expect(i, ea, ewe, epw, elv, ehl);
            mask = (32'd1 << m_cntw[i]) - 32'd1;
            chk($sformatf("m%0d.state", i), 32'(d_s[i]), 32'(m_phase[i]));
            chk($sformatf("m%0d.addr", i), 32'(d_a[i]), 32'(ea));
            chk($sformatf("m%0d.we", i), 32'(d_we[i]), 32'(ewe));
            chk($sformatf("m%0d.pcwe", i), 32'(d_pw[i]), 32'(epw));
            chk($sformatf("m%0d.lv", i), 32'(d_lv[i]), 32'(elv));
            chk($sformatf("m%0d.halted", i), 32'(d_h[i]), 32'(ehl));
            chk($sformatf("m%0d.ir", i), 32'(d_ir[i]), 32'(m_ir[i]));
            chk($sformatf("m%0d.retired", i), 32'(d_ret[i]), m_ret[i] & mask);
        end
        @(posedge clock);
        if (reset) begin m_advance(0); m_advance(1); end
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 0; msel = 0; mwr = 0; halt = 0; stall = 0;
        cycle();
        cycle();
        chk("rst.state", 32'({s0, s2}), 32'd0);
        chk("rst.strobes", 32'({we0, pw0, lv0, we2, pw2, lv2}), 32'd0);
        chk("rst.halted", 32'({h0, h2}), 32'd0);
        chk("rst.ir", 32'(ir0 | ir2), 32'd0);
        chk("rst.retired", 32'(c2 | {12'b0, c0}), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  st;
        logic [7:0]  addr;
        logic        we, pw, lv;
        logic [15:0] ir, ret;
    } vec_t;

    vec_t tbl[7];
    int   pulses;
    int   strobes;

    initial begin
        // MEM_LAT=2 load from 0x40 with PC=0x10, read data 0xBEEF, on u2
        tbl[0] = '{3'd0, 8'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
        tbl[1] = '{3'd0, 8'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
        tbl[2] = '{3'd0, 8'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 16'd0};
        tbl[3] = '{3'd1, 8'h40, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'd0};
        tbl[4] = '{3'd2, 8'h40, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'd0};
        tbl[5] = '{3'd2, 8'h40, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'd0};
        tbl[6] = '{3'd0, 8'h10, 1'b0, 1'b0, 1'b0, 16'hBEEF, 16'd1};

        @(negedge clock);

        // Multi-cycle load through LOAD_WAIT
        do_reset();
        pc_address = 8'h10; alu_address = 8'h40; msel = 1; mwr = 0; rdata = 16'hBEEF;
        reset = 1;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("ld[%0d].state", k), 32'(s2), 32'(tbl[k].st));
            chk($sformatf("ld[%0d].addr", k), 32'(a2), 32'(tbl[k].addr));
            chk($sformatf("ld[%0d].we", k), 32'(we2), 32'(tbl[k].we));
            chk($sformatf("ld[%0d].pcwe", k), 32'(pw2), 32'(tbl[k].pw));
            chk($sformatf("ld[%0d].lv", k), 32'(lv2), 32'(tbl[k].lv));
            chk($sformatf("ld[%0d].ir", k), 32'(ir2), 32'(tbl[k].ir));
            chk($sformatf("ld[%0d].retired", k), 32'(c2), 32'(tbl[k].ret));
            cycle();
        end

        // ALU instruction with zero latency
        do_reset();
        pc_address = 8'h00; msel = 0; rdata = 16'h1234;
        reset = 1;
        cycle();
        #1;
        chk("alu.ir", 32'(ir0), 32'h1234);
        chk("alu.pcwe", 32'(pw0), 32'd1);
        cycle();
        #1;
        chk("alu.retired", 32'(c0), 32'd1);
        cycle();

        // Store held off by a 3-cycle stall in EXECUTE
        do_reset();
        pc_address = 8'h20; alu_address = 8'h80; msel = 1; mwr = 1; rdata = 16'h0;
        reset = 1;
        cycle();
        pulses = 0;
        stall = 1;
        repeat (3) begin
            #1;
            chk("st.stalled_we", 32'(we0), 32'd0);
            chk("st.stalled_addr", 32'(a0), 32'h80);
            pulses += int'(we0);
            cycle();
        end
        stall = 0;
        #1;
        chk("st.release_we", 32'(we0), 32'd1);
        chk("st.release_addr", 32'(a0), 32'h80);
        pulses += int'(we0);
        cycle();
        msel = 0;
        repeat (4) begin
            #1;
            pulses += int'(we0);
            cycle();
        end
        chk("st.pulses", 32'(pulses), 32'd1);

        // HLT after five instructions
        do_reset();
        msel = 0; pc_address = 8'h30;
        reset = 1;
        repeat (10) cycle();
        halt = 1;
        strobes = 0;
        repeat (110) begin
            #1;
            strobes += int'(we0) + int'(pw0) + int'(lv0);
            cycle();
        end
        chk("hlt.halted", 32'(h0), 32'd1);
        chk("hlt.retired", 32'(c0), 32'd5);
        chk("hlt.strobes", 32'(strobes), 32'd0);
        halt = 0;

        // Asynchronous reset in the first LOAD_WAIT cycle of a second load
        do_reset();
        pc_address = 8'h10; alu_address = 8'h40; msel = 1; mwr = 0; rdata = 16'h5A5A;
        reset = 1;
        repeat (10) cycle();
        #1;
        chk("arst.pre_state", 32'(s2), 32'd2);
        chk("arst.pre_retired", 32'(c2), 32'd1);
        reset = 0;
        #1;
        chk("arst.state", 32'(s2), 32'd0);
        chk("arst.strobes", 32'({we2, pw2, lv2, h2}), 32'd0);
        chk("arst.addr", 32'(a2), 32'h10);
        chk("arst.ir", 32'(ir2), 32'd0);
        chk("arst.retired", 32'(c2), 32'd0);
        cycle();
        reset = 1;
        #1;
        chk("arst.refetch_addr", 32'(a2), 32'h10);
        cycle();

        // 17 instructions wrap a 4-bit retired counter to 1
        do_reset();
        msel = 0;
        reset = 1;
        repeat (34) cycle();
        #1;
        chk("wrap.retired", 32'(c0), 32'd1);
        cycle();

        // Randomized traffic against the reference model
        do_reset();
        reset = 1;
        repeat (3000) begin
            pc_address  = 8'($urandom);
            alu_address = 8'($urandom);
            msel        = 1'($urandom_range(0, 1));
            mwr         = 1'($urandom_range(0, 1));
            halt        = ($urandom_range(0, 39) == 0);
            stall       = ($urandom_range(0, 4) == 0);
            rdata       = 16'($urandom);
            reset       = ($urandom_range(0, 79) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
